// File: rtl/wos_pkg.sv
// Shared definitions for the weighted-order-statistics command controller.
// Contents: opcode byte values, FSM state encoding (drives the LED state
// output), sticky error codes, acknowledge-byte prefixes and the helper that
// sizes the mask load in bytes.
package wos_pkg;

    localparam logic [7:0] OP_PARAM = 8'h01;
    localparam logic [7:0] OP_MASK  = 8'h02;
    localparam logic [7:0] OP_IMAGE = 8'h03;
    localparam logic [7:0] OP_RUN   = 8'h04;
    localparam logic [7:0] OP_READ  = 8'h05;

    localparam logic [7:0] ACK_OK  = 8'hA0;
    localparam logic [7:0] ACK_ERR = 8'hE0;

    localparam logic [2:0] ERR_NONE   = 3'd0;
    localparam logic [2:0] ERR_OPCODE = 3'd1;
    localparam logic [2:0] ERR_PARAM  = 3'd2;
    localparam logic [2:0] ERR_DROP   = 3'd3;
    localparam logic [2:0] ERR_NORUN  = 3'd4;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_PARAM   = 4'd1,
        S_MASK    = 4'd2,
        S_IMAGE   = 4'd3,
        S_RUN     = 4'd4,
        S_RD_ADDR = 4'd5,
        S_RD_WAIT = 4'd6,
        S_RD_SEND = 4'd7,
        S_ACK     = 4'd8
    } wos_state_e;

    // Number of bytes needed to carry a mask of the given bit count.
    function automatic int mask_bytes(input int bits);
        return (bits + 7) / 8;
    endfunction

endpackage

// File: rtl/wos_cmd_ctrl_if.sv
// Host-side bus of the command controller.
// master: the controller (consumes rx stream, RAM read data, tx_ready and
//         kernel_done; drives tx stream, kernel parameters, mask, RAM
//         address/write strobe, run, err and state).
// slave:  the surrounding system (UART wrappers, RAMs, address handler).
interface wos_cmd_ctrl_if #(
    parameter int DATA_BITS = 8,
    parameter int MAX_N     = 3,
    parameter int ADDR_BITS = 9
);
    localparam int MASK_BITS = MAX_N * MAX_N;

    logic                 rx_valid;
    logic [7:0]           rx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [7:0]           tx_data;
    logic [DATA_BITS-1:0] n;
    logic [DATA_BITS-1:0] h;
    logic [DATA_BITS-1:0] w;
    logic [DATA_BITS-1:0] r;
    logic [MASK_BITS-1:0] mask;
    logic [ADDR_BITS-1:0] mem_addr;
    logic                 in_w_en;
    logic [DATA_BITS-1:0] out_rd_data;
    logic                 run;
    logic                 kernel_done;
    logic [2:0]           err;
    logic [3:0]           state;

    modport master (
        input  rx_valid, rx_data, tx_ready, out_rd_data, kernel_done,
        output tx_valid, tx_data, n, h, w, r, mask, mem_addr, in_w_en,
               run, err, state
    );

    modport slave (
        output rx_valid, rx_data, tx_ready, out_rd_data, kernel_done,
        input  tx_valid, tx_data, n, h, w, r, mask, mem_addr, in_w_en,
               run, err, state
    );
endinterface

// File: rtl/wos_byte_counter.sv
// Byte counter shared by the PARAM, MASK, IMAGE and READ phases.
// Ports: clk, rst (sync, active-high); clr_i clears (wins over inc_i);
// inc_i advances by one; term_i terminal count; cnt_o current count;
// done_o = (cnt == term); last_o = (cnt + 1 == term), i.e. the byte being
// accepted now is the final one.
module wos_byte_counter #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    input  logic [W-1:0] term_i,
    output logic [W-1:0] cnt_o,
    output logic         done_o,
    output logic         last_o
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear has priority over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {W{1'b0}};
        end else if (inc_i) begin
            cnt_d = cnt_q + W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign done_o = (cnt_q == term_i);
    assign last_o = ((cnt_q + W'(1)) == term_i);
endmodule

// File: rtl/wos_cmd_ctrl.sv
// Host-side command controller for the weighted-order-statistics filter.
// Decodes an opcode-framed rx byte stream to load kernel parameters
// (validated, committed atomically), mask and image, runs the kernel and
// streams the output RAM back over a ready/valid tx port.
// Ports: clk, rst (sync, active-high), bus (wos_cmd_ctrl_if.master).
// Optional feature macro WOS_ACK_EN: when defined, each command completion
// sends one acknowledge byte (0xA0|opcode on success, 0xE0|err on failure)
// before returning to IDLE; when undefined, tx carries only READ data.
module wos_cmd_ctrl
    import wos_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int MAX_N     = 3,
    parameter int ADDR_BITS = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    wos_cmd_ctrl_if.master        bus
);
    localparam int MASK_BITS  = MAX_N * MAX_N;
    localparam int MASK_BYTES = mask_bytes(MASK_BITS);
    localparam int CW         = ADDR_BITS + 1;
    localparam int PW         = 2 * DATA_BITS;
    localparam logic [32:0] DEPTH = 33'(1) << ADDR_BITS;

`ifdef WOS_ACK_EN
    localparam wos_state_e DONE_ST = S_ACK;
`else
    localparam wos_state_e DONE_ST = S_IDLE;
`endif

    wos_state_e state_q, state_d;
    logic [DATA_BITS-1:0] n_q, h_q, w_q, r_q, n_d, h_d, w_d, r_d;
    logic [DATA_BITS-1:0] sh_n_q, sh_h_q, sh_w_q, sh_n_d, sh_h_d, sh_w_d;
    logic [MASK_BITS-1:0] mask_q, mask_d;
    logic [2:0]           err_q, err_d;
    logic                 param_ok_q, param_ok_d;
    logic                 tx_valid_q, tx_valid_d;
    logic [7:0]           tx_data_q, tx_data_d;

    logic [CW-1:0]        cnt_s, term_s;
    logic                 cnt_clr_s, cnt_inc_s, cnt_done_s, cnt_last_s;
    logic                 in_w_en_s, tx_fire_s, param_valid_s;
    logic [DATA_BITS-1:0] rx_byte_s;
    logic [PW-1:0]        hw_s, sh_hw_s, nn_s;

    assign rx_byte_s = DATA_BITS'(bus.rx_data);
    assign tx_fire_s = tx_valid_q & bus.tx_ready;
    assign hw_s      = {{DATA_BITS{1'b0}}, h_q} * {{DATA_BITS{1'b0}}, w_q};
    assign sh_hw_s   = {{DATA_BITS{1'b0}}, sh_h_q} * {{DATA_BITS{1'b0}}, sh_w_q};
    assign nn_s      = {{DATA_BITS{1'b0}}, sh_n_q} * {{DATA_BITS{1'b0}}, sh_n_q};

    // The 4th PARAM byte (r) is still on rx_data when the set is judged.
    assign param_valid_s = sh_n_q[0]
                         && (sh_n_q <= DATA_BITS'(MAX_N))
                         && (sh_hw_s != {PW{1'b0}})
                         && (33'(sh_hw_s) <= DEPTH)
                         && (rx_byte_s != {DATA_BITS{1'b0}})
                         && ({{DATA_BITS{1'b0}}, rx_byte_s} <= nn_s);

    // Terminal count for the active phase; committed h*w always fits CW bits.
    always_comb begin
        case (state_q)
            S_PARAM: term_s = CW'(4);
            S_MASK:  term_s = CW'(MASK_BYTES);
            default: term_s = CW'(hw_s);
        endcase
    end

    wos_byte_counter #(.W(CW)) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (cnt_clr_s),
        .inc_i  (cnt_inc_s),
        .term_i (term_s),
        .cnt_o  (cnt_s),
        .done_o (cnt_done_s),
        .last_o (cnt_last_s)
    );

`ifdef WOS_ACK_EN
    logic [7:0] ack_byte_s;

    // Acknowledge byte for the command completing in the current cycle.
    always_comb begin
        case (state_q)
            S_IDLE:    ack_byte_s = ACK_ERR | {5'd0, ERR_NORUN};
            S_PARAM:   ack_byte_s = param_valid_s ? (ACK_OK | OP_PARAM)
                                                  : (ACK_ERR | {5'd0, ERR_PARAM});
            S_MASK:    ack_byte_s = ACK_OK | OP_MASK;
            S_IMAGE:   ack_byte_s = ACK_OK | OP_IMAGE;
            S_RUN:     ack_byte_s = ACK_OK | OP_RUN;
            S_RD_ADDR: ack_byte_s = ACK_OK | OP_READ;
            default:   ack_byte_s = 8'h00;
        endcase
    end
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.rx_valid) begin
                    case (bus.rx_data)
                        OP_PARAM: state_d = S_PARAM;
                        OP_MASK:  state_d = S_MASK;
                        OP_IMAGE: state_d = S_IMAGE;
                        OP_RUN:   state_d = param_ok_q ? S_RUN : DONE_ST;
                        OP_READ:  state_d = S_RD_ADDR;
                        default:  state_d = S_IDLE;
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PARAM, S_MASK: begin
                if (bus.rx_valid && cnt_last_s) state_d = DONE_ST;
                else                            state_d = state_q;
            end
            S_IMAGE: begin
                // done covers an empty (h*w == 0) image.
                if (cnt_done_s || (bus.rx_valid && cnt_last_s)) state_d = DONE_ST;
                else                                             state_d = S_IMAGE;
            end
            S_RUN: begin
                if (bus.kernel_done) state_d = DONE_ST;
                else                 state_d = S_RUN;
            end
            S_RD_ADDR: begin
                if (cnt_done_s) state_d = DONE_ST;
                else            state_d = S_RD_WAIT;
            end
            S_RD_WAIT: state_d = S_RD_SEND;
            S_RD_SEND: begin
                if (tx_fire_s) state_d = S_RD_ADDR;
                else           state_d = S_RD_SEND;
            end
`ifdef WOS_ACK_EN
            S_ACK: begin
                if (tx_fire_s) state_d = S_IDLE;
                else           state_d = S_ACK;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // FSM output and datapath next-value logic.
    always_comb begin
        n_d = n_q;  h_d = h_q;  w_d = w_q;  r_d = r_q;
        sh_n_d = sh_n_q;  sh_h_d = sh_h_q;  sh_w_d = sh_w_q;
        mask_d     = mask_q;
        err_d      = err_q;
        param_ok_d = param_ok_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        cnt_clr_s  = (state_q == S_IDLE);
        cnt_inc_s  = 1'b0;
        in_w_en_s  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.rx_valid) begin
                    case (bus.rx_data)
                        OP_PARAM, OP_MASK, OP_IMAGE, OP_READ: err_d = err_q;
                        OP_RUN:  err_d = param_ok_q ? err_q : ERR_NORUN;
                        default: err_d = ERR_OPCODE;
                    endcase
                end else begin
                    err_d = err_q;
                end
            end
            S_PARAM: begin
                if (bus.rx_valid) begin
                    cnt_inc_s = 1'b1;
                    case (cnt_s[1:0])
                        2'd0: sh_n_d = rx_byte_s;
                        2'd1: sh_h_d = rx_byte_s;
                        2'd2: sh_w_d = rx_byte_s;
                        default: begin
                            if (param_valid_s) begin
                                n_d = sh_n_q;  h_d = sh_h_q;  w_d = sh_w_q;
                                r_d = rx_byte_s;
                                err_d      = ERR_NONE;
                                param_ok_d = 1'b1;
                            end else begin
                                err_d = ERR_PARAM;
                            end
                        end
                    endcase
                end else begin
                    cnt_inc_s = 1'b0;
                end
            end
            S_MASK: begin
                if (bus.rx_valid) begin
                    cnt_inc_s = 1'b1;
                    for (int i = 0; i < MASK_BITS; i++) begin
                        if (cnt_s == CW'(i / 8)) mask_d[i] = bus.rx_data[i % 8];
                        else                     mask_d[i] = mask_q[i];
                    end
                end else begin
                    cnt_inc_s = 1'b0;
                end
            end
            S_IMAGE: begin
                in_w_en_s = bus.rx_valid & ~cnt_done_s;
                cnt_inc_s = bus.rx_valid & ~cnt_done_s;
            end
            S_RUN, S_RD_ADDR: begin
                if (bus.rx_valid) err_d = ERR_DROP;
                else              err_d = err_q;
            end
            S_RD_WAIT: begin
                // RAM data for the address shown in RD_ADDR is valid now.
                tx_data_d  = 8'(bus.out_rd_data);
                tx_valid_d = 1'b1;
                if (bus.rx_valid) err_d = ERR_DROP;
                else              err_d = err_q;
            end
            S_RD_SEND, S_ACK: begin
                if (tx_fire_s) begin
                    tx_valid_d = 1'b0;
                    cnt_inc_s  = (state_q == S_RD_SEND);
                end else begin
                    tx_valid_d = 1'b1;
                end
                if (bus.rx_valid) err_d = ERR_DROP;
                else              err_d = err_q;
            end
            default: cnt_clr_s = 1'b1;
        endcase
`ifdef WOS_ACK_EN
        if ((state_d == S_ACK) && (state_q != S_ACK)) begin
            tx_valid_d = 1'b1;
            tx_data_d  = ack_byte_s;
        end else begin
            tx_data_d = tx_data_d;
        end
`endif
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            n_q <= DATA_BITS'(3);
            h_q <= {DATA_BITS{1'b0}};
            w_q <= {DATA_BITS{1'b0}};
            r_q <= {DATA_BITS{1'b0}};
            sh_n_q <= {DATA_BITS{1'b0}};
            sh_h_q <= {DATA_BITS{1'b0}};
            sh_w_q <= {DATA_BITS{1'b0}};
            mask_q     <= {MASK_BITS{1'b1}};
            err_q      <= ERR_NONE;
            param_ok_q <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            n_q <= n_d;  h_q <= h_d;  w_q <= w_d;  r_q <= r_d;
            sh_n_q <= sh_n_d;  sh_h_q <= sh_h_d;  sh_w_q <= sh_w_d;
            mask_q     <= mask_d;
            err_q      <= err_d;
            param_ok_q <= param_ok_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
        end
    end

    assign bus.n        = n_q;
    assign bus.h        = h_q;
    assign bus.w        = w_q;
    assign bus.r        = r_q;
    assign bus.mask     = mask_q;
    assign bus.err      = err_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.mem_addr = cnt_s[ADDR_BITS-1:0];
    assign bus.in_w_en  = in_w_en_s;
    assign bus.state    = state_q;
    // run must fall in the reset cycle itself, not one cycle later.
    assign bus.run      = (state_q == S_RUN) & ~rst;
endmodule

// File: tb/tb_wos_cmd_ctrl.sv
// Directed testbench for wos_cmd_ctrl (default build, WOS_ACK_EN undefined).
// A behavioural RAM stands in for the input/output memories so READ returns
// the bytes written by IMAGE.
module tb_wos_cmd_ctrl;
    localparam int DB = 8;
    localparam int MN = 3;
    localparam int AB = 9;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    wos_cmd_ctrl_if #(.DATA_BITS(DB), .MAX_N(MN), .ADDR_BITS(AB)) bus ();

    wos_cmd_ctrl #(.DATA_BITS(DB), .MAX_N(MN), .ADDR_BITS(AB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] ram [0:(1<<AB)-1];

    // Shared image/result RAM with one-cycle read latency.
    always @(posedge clk) begin
        if (bus.in_w_en) ram[bus.mem_addr] <= bus.rx_data;
        bus.out_rd_data <= ram[bus.mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_param(input logic [7:0] n, input logic [7:0] h,
                              input logic [7:0] w, input logic [7:0] r);
        send_byte(8'h01); send_byte(n); send_byte(h); send_byte(w); send_byte(r);
    endtask

    initial begin
        logic       pv, pr;
        logic [7:0] pd;
        int         got;
        for (int i = 0; i < (1 << AB); i++) ram[i] = 8'h00;
        bus.rx_valid = 1'b0;  bus.rx_data = 8'h00;
        bus.tx_ready = 1'b1;  bus.kernel_done = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_state", 32'(bus.state), 32'd0);
        check("rst_n", 32'(bus.n), 32'd3);
        check("rst_hwr", 32'({bus.h, bus.w, bus.r}), 32'd0);
        check("rst_mask", 32'(bus.mask), 32'h1FF);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_ctl", 32'({bus.tx_valid, bus.run, bus.in_w_en}), 32'd0);
        check("rst_addr", 32'(bus.mem_addr), 32'd0);

        // RUN before any valid PARAM, then an unknown opcode
        send_byte(8'h04);
        check("run_refused_err", 32'(bus.err), 32'd4);
        check("run_refused_state", 32'(bus.state), 32'd0);
        send_byte(8'h07);
        check("bad_op_err", 32'(bus.err), 32'd1);

        // Invalid parameter sets leave registers unchanged
        send_param(8'h02, 8'h04, 8'h04, 8'h05);
        check("even_n_err", 32'(bus.err), 32'd2);
        check("even_n_regs", 32'({bus.n, bus.h, bus.w, bus.r}), 32'h03000000);
        send_param(8'h03, 8'h20, 8'h20, 8'h05);
        check("big_hw_err", 32'(bus.err), 32'd2);
        check("big_hw_h", 32'(bus.h), 32'd0);
        send_param(8'h03, 8'h04, 8'h04, 8'h0A);
        check("big_r_err", 32'(bus.err), 32'd2);
        check("big_r_r", 32'(bus.r), 32'd0);

        // h*w exactly 512 and r = n*n = 1 are accepted; commit clears err
        send_param(8'h01, 8'h10, 8'h20, 8'h01);
        check("hw512_regs", 32'({bus.n, bus.h, bus.w, bus.r}), 32'h01102001);
        check("hw512_err", 32'(bus.err), 32'd0);

        send_param(8'h03, 8'h04, 8'h04, 8'h05);
        check("p44_regs", 32'({bus.n, bus.h, bus.w, bus.r}), 32'h03040405);
        check("p44_err", 32'(bus.err), 32'd0);
        check("p44_state", 32'(bus.state), 32'd0);

        // MASK loads, high bits of the last byte dropped
        send_byte(8'h02); send_byte(8'h0F); send_byte(8'h00);
        check("mask_0f", 32'(bus.mask), 32'h00F);
        send_byte(8'h02); send_byte(8'hFF); send_byte(8'h01);
        check("mask_1ff", 32'(bus.mask), 32'h1FF);
        send_byte(8'h02); send_byte(8'h00); send_byte(8'hFE);
        check("mask_drop", 32'(bus.mask), 32'h000);
        send_byte(8'h02); send_byte(8'h0F); send_byte(8'h00);
        check("mask_0f_again", 32'(bus.mask), 32'h00F);

        // IMAGE of 16 bytes: write strobe and address per byte
        send_byte(8'h03);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            bus.rx_valid = 1'b1;
            bus.rx_data  = 8'h30 + 8'(i);
            #1;
            check("img_wen", 32'(bus.in_w_en), 32'd1);
            check("img_addr", 32'(bus.mem_addr), 32'(i));
            if (i == 15) check("img_state_mid", 32'(bus.state), 32'd3);
            @(negedge clk);
            bus.rx_valid = 1'b0;
        end
        check("img_state_end", 32'(bus.state), 32'd0);
        check("img_wen_end", 32'(bus.in_w_en), 32'd0);

        // RUN with a stray rx byte, kernel_done at cycle 40
        send_byte(8'h04);
        check("run_hi", 32'(bus.run), 32'd1);
        repeat (18) @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h55;
        #1;
        check("run_rx_no_wen", 32'(bus.in_w_en), 32'd0);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        check("run_drop_err", 32'(bus.err), 32'd3);
        check("run_still_hi", 32'(bus.run), 32'd1);
        repeat (19) @(negedge clk);
        bus.kernel_done = 1'b1;
        check("run_hi_at_done", 32'(bus.run), 32'd1);
        @(negedge clk);
        bus.kernel_done = 1'b0;
        check("run_lo", 32'(bus.run), 32'd0);
        check("run_state", 32'(bus.state), 32'd0);

        // READ with tx_ready toggling every cycle
        send_byte(8'h05);
        got = 0;  pv = 1'b0;  pr = 1'b1;  pd = 8'h00;
        for (int c = 0; c < 300 && got < 16; c++) begin
            @(negedge clk);
            bus.tx_ready = ~bus.tx_ready;
            #1;
            if (pv && !pr) begin
                check("rd_hold_valid", 32'(bus.tx_valid), 32'd1);
                check("rd_hold_data", 32'(bus.tx_data), 32'(pd));
            end
            if (bus.tx_valid && bus.tx_ready) begin
                check("rd_data", 32'(bus.tx_data), 32'(8'h30 + 8'(got)));
                got++;
            end
            pv = bus.tx_valid;  pr = bus.tx_ready;  pd = bus.tx_data;
        end
        check("rd_count", 32'(got), 32'd16);
        bus.tx_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("rd_state_end", 32'(bus.state), 32'd0);
        check("rd_no_extra", 32'(bus.tx_valid), 32'd0);
        check("err_sticky", 32'(bus.err), 32'd3);

        // Reset in the middle of PARAM discards it and the valid flag
        send_byte(8'h01); send_byte(8'h03); send_byte(8'h02);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("mid_rst_state", 32'(bus.state), 32'd0);
        check("mid_rst_regs", 32'({bus.n, bus.h, bus.w, bus.r}), 32'h03000000);
        check("mid_rst_err", 32'(bus.err), 32'd0);
        send_byte(8'h04);
        check("post_rst_run_refused", 32'(bus.err), 32'd4);

        // Reset during RUN drops run in the same cycle
        send_param(8'h03, 8'h04, 8'h04, 8'h05);
        check("p44b_err", 32'(bus.err), 32'd0);
        send_byte(8'h04);
        repeat (3) @(negedge clk);
        check("run2_hi", 32'(bus.run), 32'd1);
        rst = 1'b1;
        #1;
        check("run_rst_drop", 32'(bus.run), 32'd0);
        @(negedge clk); rst = 1'b0;
        check("run_rst_state", 32'(bus.state), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/wos_cmd_ctrl.md
Name: wos_cmd_ctrl

Overview:
- Parametrised host-side command controller for the weighted-order-statistics filter; successor to the hard-wired FSM, byte counter and write-enable mux.
- Decodes an opcode-framed byte stream to load kernel parameters, mask and image, run the kernel, and stream results back.
- Sits between the UART rx/tx wrappers and the parameter/mask registers, input/output RAMs and address handler.
- Generalised over data width, max kernel size and memory depth; adds parameter validation, error reporting and tx back-pressure.

Parameters:
- DATA_BITS, 8, pixel and parameter width.
- MAX_N, 3, maximum kernel side.
- ADDR_BITS, 9, image memory address width; depth is 2**ADDR_BITS.
- MASK_BITS, MAX_N*MAX_N, derived (localparam).
- MASK_BYTES, ceil(MASK_BITS/8), derived (localparam).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- rx_valid  in  1  one-cycle strobe, rx_data valid
- rx_data  in  8  received byte
- tx_valid  out  1  tx_data valid; held until tx_ready
- tx_ready  in  1  transmitter can accept a byte
- tx_data  out  8  byte to send
- n, h, w, r  out  DATA_BITS each  kernel side, height, width, rank
- mask  out  MASK_BITS  kernel mask; bit i is byte i/8, bit i%8
- mem_addr  out  ADDR_BITS  host-side RAM address
- in_w_en  out  1  input RAM write strobe; data is rx_data
- out_rd_data  in  DATA_BITS  output RAM data, one cycle after mem_addr
- run  out  1  level; kernel owns the RAMs while high
- kernel_done  in  1  from the address handler
- err  out  3  sticky error code; 0 means none
- state  out  4  current state for LEDs

Behaviour:
- Reset values: state=IDLE; n=3, h=0, w=0, r=0; mask all ones; err=0; tx_valid=0; run=0; in_w_en=0; mem_addr=0.
- Opcodes arrive in IDLE:
  - 0x01 PARAM: capture 4 bytes n,h,w,r.
  - 0x02 MASK: capture MASK_BYTES bytes.
  - 0x03 IMAGE: capture h*w bytes.
  - 0x04 RUN.
  - 0x05 READ.
  - Any other opcode: err=1, stay in IDLE.
- States: IDLE, PARAM, MASK, IMAGE, RUN, RD_ADDR, RD_WAIT, RD_SEND, ACK.
- Byte counter cnt is ADDR_BITS+1 wide. It clears on every entry to a load or read state and increments on each accepted byte.
- PARAM: bytes go to a shadow register. They are committed only after the 4th byte, and only if:
  - n is odd, 1<=n<=MAX_N;
  - h*w is nonzero and h*w<=2**ADDR_BITS;
  - 1<=r<=n*n.
  - Otherwise the old values are kept and err=2.
- MASK: byte k writes mask[8k+7:8k]. Bits at or above MASK_BITS are dropped.
- IMAGE: each rx_valid asserts in_w_en in the same cycle, with mem_addr=cnt. The state leaves after h*w bytes.
- h*w computed full-width (2*DATA_BITS), no truncation.
- RUN:
  - run=1 from the cycle after decode until kernel_done is sampled high; then run=0 and return to IDLE.
  - rx bytes arriving during RUN are dropped and set err=3.
  - RUN is refused with err=4 if no valid PARAM has been committed since reset.
- READ: RD_ADDR drives mem_addr=cnt, then RD_WAIT (1 cycle), then RD_SEND latches out_rd_data into tx_data with tx_valid=1.
  - The handshake completes on tx_valid&tx_ready; cnt increments.
  - Loops until cnt==h*w, then IDLE.
- rx_valid during a tx stall in READ: byte dropped, err=3.
- err is sticky; it is cleared only by rst or by a PARAM commit that succeeds.
- rst mid-operation: outputs take reset values next cycle; run drops immediately; a partial PARAM is discarded.

Optional Feature:
- WOS_ACK_EN:
  - When defined, every command completion enters ACK and sends one byte through the tx handshake: 0xA0|opcode on success, 0xE0|err on failure. READ sends its ack after its last data byte. Then the block returns to IDLE.
  - When undefined, the ACK state is absent and tx is used only by READ.

Decomposition:
- Package wos_pkg: opcode constants, state enum, error codes, ACK_OK and ACK_ERR prefixes, the MASK_BYTES function.
- One sub-module, wos_byte_counter: width parameter, clear and increment inputs, terminal-count compare output. It is reused by the IMAGE, MASK and READ states.

Test Plan:
- PARAM 01 03 04 04 05 → n=3, h=4, w=4, r=5, err=0; with WOS_ACK_EN, tx byte 0xA1.
- PARAM 01 02 04 04 05 (even n) → registers unchanged, err=2; PARAM 01 03 20 20 05 with ADDR_BITS=9 (1024>512) → err=2.
- MASK 02 FF 01 with MAX_N=3 → mask=9'h1FF; then 02 0F 00 → mask=9'h00F.
- IMAGE of 16 bytes 0..15 after a valid 4x4 PARAM → in_w_en pulses at addr 0..15 with data matching; state returns to IDLE after the 16th byte.
- RUN → run high until kernel_done pulse at cycle 40, low the next cycle; an rx byte injected at cycle 20 → err=3.
- READ with tx_ready toggling 1/0 every cycle → 16 bytes sent in address order with no duplicates; tx_data stable while tx_valid&~tx_ready.
